pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline register: the generic successor to the fixed ex/mem-style stage latches, for use between any two CPU stages (if/id, id/ex, ex/mem, mem/wb). It carries an opaque payload plus PC, exception vector and bad-address fields. Transfers use a valid/ready handshake in both directions. A synchronous flush drops all held entries and replaces them with a bubble carrying a redirect PC. An optional 2-entry skid buffer registers the upstream ready for full throughput without a combinational ready path.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_stage_reg_if.sv | 51 +++++
 rtl/pipe_stage_merge.sv | 23 ++
 rtl/pipe_stage_reg.sv | 176 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage register.
// Contents: occupancy state encoding, the index of the fetch exception bit,
// and default widths / reset PC that stage wrappers use as parameter defaults.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF    = 64;
  localparam int unsigned PC_W_DEF      = 32;
  localparam int unsigned EXC_W_DEF     = 8;
  localparam logic [31:0] RESET_PC_DEF  = 32'hBFC0_0000;

  // Exception bit raised by fetch; when set, the PC itself is the bad address.
  localparam int unsigned EXC_FETCH_BIT = 0;

  // Number of entries held by the stage.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage: upstream side (in_*), downstream
// side (out_*) and the flush request.
// Modports:
//   slave  - the stage register itself (consumes in_*, produces out_*).
//   master - the environment around the stage (produces in_*, consumes out_*).
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned PC_W   = PC_W_DEF,
  parameter int unsigned EXC_W  = EXC_W_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [PC_W-1:0]   in_pc;
  logic [EXC_W-1:0]  in_exc;
  logic [PC_W-1:0]   in_bad_addr;
  logic              in_kernel;
  logic              in_delay_slot;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PC_W-1:0]   out_pc;
  logic [EXC_W-1:0]  out_exc;
  logic [PC_W-1:0]   out_bad_addr;
  logic              out_kernel;
  logic              out_delay_slot;

  logic              flush;
  logic [PC_W-1:0]   flush_target;

  modport slave (
    input  in_valid, in_data, in_pc, in_exc, in_bad_addr, in_kernel, in_delay_slot,
    output in_ready,
    output out_valid, out_data, out_pc, out_exc, out_bad_addr, out_kernel, out_delay_slot,
    input  out_ready,
    input  flush, flush_target
  );

  modport master (
    output in_valid, in_data, in_pc, in_exc, in_bad_addr, in_kernel, in_delay_slot,
    input  in_ready,
    input  out_valid, out_data, out_pc, out_exc, out_bad_addr, out_kernel, out_delay_slot,
    output out_ready,
    output flush, flush_target
  );

endinterface

// File: rtl/pipe_stage_merge.sv
// Combinational input-side merge shared by registered and unregistered stages.
// Ports:
//   in_exc_fetch  - fetch exception flag of the incoming instruction
//   in_pc         - instruction PC
//   in_bad_addr   - faulting data address from the producing stage
//   in_kernel     - privileged-instruction marker
//   bad_addr_c    - PC on a fetch fault, otherwise the data address
//   kernel_c      - marker OR'd with the PC's top (kernel segment) bit
module pipe_stage_merge #(
  parameter int unsigned PC_W = 32
) (
  input  logic            in_exc_fetch,
  input  logic [PC_W-1:0] in_pc,
  input  logic [PC_W-1:0] in_bad_addr,
  input  logic            in_kernel,
  output logic [PC_W-1:0] bad_addr_c,
  output logic            kernel_c
);

  assign bad_addr_c = in_exc_fetch ? in_pc : in_bad_addr;
  assign kernel_c   = in_kernel | in_pc[PC_W-1];

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register between two CPU stages with valid/ready handshake,
// synchronous flush-to-bubble and an optional 2-entry skid buffer.
// Build option: define PIPE_STAGE_SKID_EN for the skid buffer (registered
// in_ready); otherwise a single register with combinational in_ready.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - pipe_stage_reg_if.slave: in_* upstream, out_* downstream, flush
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned     DATA_W   = DATA_W_DEF,
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter int unsigned     EXC_W    = EXC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input logic              clock,
  input logic              reset,
  pipe_stage_reg_if.slave  bus
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
    logic [EXC_W-1:0]  exc;
    logic [PC_W-1:0]   bad_addr;
    logic              kernel;
    logic              delay_slot;
  } entry_t;

  localparam entry_t RESET_ENT = '{
    data: '0, pc: RESET_PC, exc: '0, bad_addr: '0, kernel: 1'b0, delay_slot: 1'b0
  };

  state_e          state_q;
  logic            out_valid_q;
  entry_t          main_q;
  entry_t          in_ent_c;
  entry_t          flush_ent_c;
  logic [PC_W-1:0] merged_bad_addr_c;
  logic            merged_kernel_c;
  logic            in_ready_c;
  logic            in_fire_c;
  logic            out_fire_c;

  // Merge happens before storage so both main and skid hold final values.
  pipe_stage_merge #(
    .PC_W (PC_W)
  ) u_merge (
    .in_exc_fetch (bus.in_exc[EXC_FETCH_BIT]),
    .in_pc        (bus.in_pc),
    .in_bad_addr  (bus.in_bad_addr),
    .in_kernel    (bus.in_kernel),
    .bad_addr_c   (merged_bad_addr_c),
    .kernel_c     (merged_kernel_c)
  );

  // Incoming entry and the bubble written on flush.
  always_comb begin
    in_ent_c            = '0;
    in_ent_c.data       = bus.in_data;
    in_ent_c.pc         = bus.in_pc;
    in_ent_c.exc        = bus.in_exc;
    in_ent_c.bad_addr   = merged_bad_addr_c;
    in_ent_c.kernel     = merged_kernel_c;
    in_ent_c.delay_slot = bus.in_delay_slot;
    flush_ent_c         = '0;
    flush_ent_c.pc      = bus.flush_target;
  end

  assign in_fire_c  = bus.in_valid & in_ready_c;
  assign out_fire_c = out_valid_q & bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
  entry_t skid_q;
  logic   in_ready_q;

  assign in_ready_c = in_ready_q;

  // Occupancy FSM; in_ready_q tracks "next state is not TWO".
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_q      <= RESET_ENT;
      skid_q      <= '0;
    end else if (bus.flush) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_q      <= flush_ent_c;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_c) begin
            main_q      <= in_ent_c;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({in_fire_c, out_fire_c})
            2'b11: main_q <= in_ent_c;
            2'b10: begin
              skid_q     <= in_ent_c;
              in_ready_q <= 1'b0;
              state_q    <= ST_TWO;
            end
            2'b01: begin
              out_valid_q <= 1'b0;
              state_q     <= ST_EMPTY;
            end
            default: ;
          endcase
        end
        ST_TWO: begin
          if (out_fire_c) begin
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_EMPTY;
        end
      endcase
    end
  end
`else
  // Single register: accept whenever the held entry leaves this cycle.
  assign in_ready_c = !out_valid_q | bus.out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      main_q      <= RESET_ENT;
    end else if (bus.flush) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      main_q      <= flush_ent_c;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_c) begin
            main_q      <= in_ent_c;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        default: begin
          if (in_fire_c) begin
            main_q <= in_ent_c;
          end else if (out_fire_c) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
      endcase
    end
  end
`endif

  assign bus.in_ready       = in_ready_c;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_data       = main_q.data;
  assign bus.out_pc         = main_q.pc;
  assign bus.out_exc        = main_q.exc;
  assign bus.out_bad_addr   = main_q.bad_addr;
  assign bus.out_kernel     = main_q.kernel;
  assign bus.out_delay_slot = main_q.delay_slot;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based model of an
// elastic buffer of capacity 1 (default) or 2 (PIPE_STAGE_SKID_EN).
module tb_pipe_stage_reg;
  import pipe_pkg::*;

`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] pc;
    logic [7:0]  exc;
    logic [31:0] bad_addr;
    logic        kernel;
    logic        ds;
  } ent_t;

  localparam ent_t RST_ENT = '{pc: 32'hBFC0_0000, default: '0};

  logic clock;
  logic reset;

  pipe_stage_reg_if #(.DATA_W(64), .PC_W(32), .EXC_W(8)) bus ();

  pipe_stage_reg #(
    .DATA_W   (64),
    .PC_W     (32),
    .EXC_W    (8),
    .RESET_PC (32'hBFC0_0000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   total;
  int   bad;
  ent_t mq[$];
  ent_t held;
  ent_t cur;
  logic cur_v;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of tests");
    $fatal(1, "watchdog");
  end

  // Spec merge rules applied to a raw upstream entry.
  function automatic ent_t merged(input ent_t r);
    ent_t m = r;
    if (r.exc[0]) m.bad_addr = r.pc;
    m.kernel = r.kernel | r.pc[31];
    return m;
  endfunction

  function automatic logic exp_ready();
`ifdef PIPE_STAGE_SKID_EN
    return mq.size() < CAP;
`else
    return (mq.size() == 0) || bus.out_ready;
`endif
  endfunction

  function automatic ent_t exp_out();
    return (mq.size() > 0) ? mq[0] : held;
  endfunction

  function automatic ent_t obs();
    ent_t o;
    o.data = bus.out_data; o.pc = bus.out_pc; o.exc = bus.out_exc;
    o.bad_addr = bus.out_bad_addr; o.kernel = bus.out_kernel; o.ds = bus.out_delay_slot;
    return o;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t r;
    r.data = {$urandom, $urandom}; r.pc = $urandom; r.exc = 8'($urandom);
    r.bad_addr = $urandom; r.kernel = 1'($urandom); r.ds = 1'($urandom);
    return r;
  endfunction

  task automatic drive(input logic v, input ent_t r);
    cur_v = v; cur = r;
    bus.in_valid = v; bus.in_data = r.data; bus.in_pc = r.pc; bus.in_exc = r.exc;
    bus.in_bad_addr = r.bad_addr; bus.in_kernel = r.kernel; bus.in_delay_slot = r.ds;
  endtask

  // Advance model and DUT by one clock.
  task automatic tick();
    logic inf, outf;
    inf  = cur_v && exp_ready();
    outf = (mq.size() > 0) && bus.out_ready;
    if (bus.flush) begin
      mq.delete();
      held = '{pc: bus.flush_target, default: '0};
    end else begin
      if (outf) held = mq.pop_front();
      if (inf) mq.push_back(merged(cur));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, '0);
    bus.out_ready = 1'b1;
    bus.flush = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, '0);
    bus.out_ready = 1'b0; bus.flush = 1'b0; bus.flush_target = '0;
    mq.delete(); held = RST_ENT;
    #3;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready); end
    total++; if (obs() !== RST_ENT) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", obs(), RST_ENT); end
    #4 reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_merge();
    ent_t r;
    drain();
    r = '{data: 64'h1, pc: 32'h0040_0000, exc: 8'h01, bad_addr: 32'h1234, default: '0};
    drive(1'b1, r); #1; tick();
    drive(1'b0, '0); #1;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL merge_valid got=%b exp=1", bus.out_valid); end
    total++; if (bus.out_bad_addr !== 32'h0040_0000) begin bad++; $display("FAIL merge_badaddr got=%h exp=00400000", bus.out_bad_addr); end
    total++; if (bus.out_kernel !== 1'b0) begin bad++; $display("FAIL merge_kernel0 got=%b exp=0", bus.out_kernel); end
    tick();
    r = '{data: 64'h2, pc: 32'h8000_0000, exc: 8'h00, bad_addr: 32'h5678, default: '0};
    drive(1'b1, r); #1; tick();
    drive(1'b0, '0); #1;
    total++; if (bus.out_kernel !== 1'b1) begin bad++; $display("FAIL merge_kernel1 got=%b exp=1", bus.out_kernel); end
    total++; if (bus.out_bad_addr !== 32'h5678) begin bad++; $display("FAIL merge_passaddr got=%h exp=5678", bus.out_bad_addr); end
    tick();
  endtask

  task automatic test_skid_build();
    ent_t r;
    int k = 0, acc = 0, n = 0;
    drain();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      r = '{data: 64'hA0 + 64'(k), pc: 32'h100 + 32'(k), default: '0};
      drive(1'b1, r); #1;
      if (bus.in_ready === 1'b1) acc++;
      if (exp_ready()) k++;
      tick();
    end
    drive(1'b0, '0); #1;
    total++; if (acc != CAP) begin bad++; $display("FAIL skid_accepts got=%0d exp=%0d", acc, CAP); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL skid_full_ready got=%b exp=0", bus.in_ready); end
    bus.out_ready = 1'b1; #1;
    for (int c = 0; c < 4; c++) begin
      if (bus.out_valid === 1'b1) begin
        total++;
        if (bus.out_data !== 64'hA0 + 64'(n)) begin bad++; $display("FAIL skid_drain_order got=%h exp=%h", bus.out_data, 64'hA0 + 64'(n)); end
        n++;
      end
      tick(); #1;
    end
    total++; if (n != CAP) begin bad++; $display("FAIL skid_drain_count got=%0d exp=%0d", n, CAP); end
  endtask

  task automatic test_flush_two();
    ent_t r;
    drain();
    bus.out_ready = 1'b0;
    for (int k = 0; k < CAP; k++) begin
      r = '{data: 64'hF00 + 64'(k), pc: 32'h200, default: '0};
      drive(1'b1, r); #1; tick();
    end
    drive(1'b0, '0); #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_prefull_ready got=%b exp=0", bus.in_ready); end
    r = '{data: 64'hDEAD, pc: 32'h300, exc: 8'h5, default: '0};
    drive(1'b1, r);
    bus.flush = 1'b1; bus.flush_target = 32'h8000_0180; #1;
    tick();
    bus.flush = 1'b0; drive(1'b0, '0); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_pc !== 32'h8000_0180) begin bad++; $display("FAIL flush_pc got=%h exp=80000180", bus.out_pc); end
    total++; if (bus.out_data !== 64'h0 || bus.out_exc !== 8'h0) begin bad++; $display("FAIL flush_clear got=%h/%h exp=0/0", bus.out_data, bus.out_exc); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost got=%b data=%h exp=0", bus.out_valid, bus.out_data); end
      tick();
    end
  endtask

  task automatic test_stream();
    ent_t r;
    int n_out = 0;
    drain();
    for (int i = 0; i <= 100; i++) begin
      r = rnd_ent();
      r.data = 64'h1000 + 64'(i);
      drive(i < 100, r); #1;
      if (i > 0) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h1000 + 64'(i - 1)) begin
          bad++; $display("FAIL stream_out i=%0d got=%b/%h exp=1/%h", i, bus.out_valid, bus.out_data, 64'h1000 + 64'(i - 1));
        end
      end
      if (i < 100) begin
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, bus.in_ready); end
      end
      if (bus.out_valid === 1'b1) n_out++;
      tick();
    end
    total++; if (n_out != 100) begin bad++; $display("FAIL stream_count got=%0d exp=100", n_out); end
  endtask

  task automatic test_random();
    drain();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 7, rnd_ent());
      bus.out_ready = 1'($urandom);
      bus.flush = ($urandom_range(0, 19) == 0);
      bus.flush_target = $urandom;
      #1;
      total++; if (bus.out_valid !== (mq.size() > 0)) begin bad++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, bus.out_valid, mq.size() > 0); end
      total++; if (bus.in_ready !== exp_ready()) begin bad++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, bus.in_ready, exp_ready()); end
      total++; if (obs() !== exp_out()) begin bad++; $display("FAIL rand_payload c=%0d got=%h exp=%h", c, obs(), exp_out()); end
      tick();
    end
    bus.flush = 1'b0;
  endtask

  task automatic test_reset_midstream();
    ent_t r;
    drain();
    bus.out_ready = 1'b0;
    for (int k = 0; k < CAP; k++) begin
      drive(1'b1, rnd_ent()); #1; tick();
    end
    drive(1'b0, '0);
    #2 reset = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.out_pc !== 32'hBFC0_0000) begin bad++; $display("FAIL rstmid_pc got=%h exp=bfc00000", bus.out_pc); end
    #1 reset = 1'b0;
    mq.delete(); held = RST_ENT;
    r = '{data: 64'h77, pc: 32'h8000_0010, default: '0};
    drive(1'b1, r); bus.out_ready = 1'b1; #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready2 got=%b exp=1", bus.in_ready); end
    tick();
    drive(1'b0, '0); #1;
    total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8000_0010) begin
      bad++; $display("FAIL rstmid_first got=%b/%h exp=1/80000010", bus.out_valid, bus.out_pc);
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_merge();
    test_skid_build();
    test_flush_two();
    test_stream();
    test_random();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
